// File: rtl/oled_frame_streamer.sv
// SSD1331 Pmod driver: power-up/reset sequencing, fixed command ROM, then a continuous
// raster scan that fetches RGB565 words by pixel_index and serialises them over SPI mode 3.
module oled_frame_streamer #(
  parameter int RESET_CYCLES   = 20,
  parameter int STARTUP_CYCLES = 100,
  parameter int NUM_PIXELS     = 6144
) (
  input  logic        clk,
  input  logic        notReset,
  input  logic [15:0] oled_data,
  output logic [12:0] pixel_index,
  output logic        frame_begin,
  output logic        sending_pixels,
  output logic        cs_n,
  output logic        sclk,
  output logic        sdin,
  output logic        d_cn,
  output logic        res_n,
  output logic        vccen,
  output logic        pmoden
);

  localparam logic [2:0] ST_RST_LO   = 3'd0;
  localparam logic [2:0] ST_RST_HI   = 3'd1;
  localparam logic [2:0] ST_CMD      = 3'd2;
  localparam logic [2:0] ST_PWR_WAIT = 3'd3;
  localparam logic [2:0] ST_STREAM   = 3'd4;

  // One shared timer serves the reset/startup waits, the command byte period and the pixel slot.
  localparam int CNT_MAX_RAW = (RESET_CYCLES > STARTUP_CYCLES) ? RESET_CYCLES : STARTUP_CYCLES;
  localparam int CNT_MAX     = (CNT_MAX_RAW < 32) ? 32 : CNT_MAX_RAW;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);

  localparam logic [3:0]  LAST_BYTE = 4'd8;
  localparam logic [12:0] LAST_PIX  = 13'(NUM_PIXELS - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       byte_idx;
  logic [15:0]      word;
  logic             primed;
  logic [7:0]       cmd_byte;
  logic             cmd_shifting;
  logic             pix_shifting;
  logic [4:0]       slot;

  assign slot = cnt[4:0];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      state       <= ST_RST_LO;
      cnt         <= '0;
      byte_idx    <= '0;
      word        <= '0;
      primed      <= 1'b0;
      pixel_index <= '0;
      pmoden      <= 1'b0;
    end else begin
      pmoden <= 1'b1;
      case (state)
        ST_RST_LO: begin
          if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
            state <= ST_RST_HI;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RST_HI: begin
          if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
            state    <= ST_CMD;
            cnt      <= '0;
            byte_idx <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CMD: begin
          // 16 clk shifting plus a 2 clk deselect gap, except after the final byte.
          if (cnt == CNT_W'(15) && byte_idx == LAST_BYTE) begin
            state <= ST_PWR_WAIT;
            cnt   <= '0;
          end else if (cnt == CNT_W'(17)) begin
            cnt      <= '0;
            byte_idx <= byte_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PWR_WAIT: begin
          if (cnt == CNT_W'(STARTUP_CYCLES - 1)) begin
            state       <= ST_STREAM;
            cnt         <= '0;
            primed      <= 1'b0;
            pixel_index <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STREAM: begin
          // The first 32 clk only prefetch pixel 0; shifting starts once a word is held.
          if (slot == 5'd31) begin
            cnt    <= '0;
            word   <= oled_data;
            primed <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
          if (slot == 5'd0 && primed) begin
            pixel_index <= (pixel_index == LAST_PIX) ? 13'd0 : pixel_index + 13'd1;
          end
        end
        default: state <= ST_RST_LO;
      endcase
    end
  end

  always_comb begin
    case (byte_idx)
      4'd0:    cmd_byte = 8'hA0;
      4'd1:    cmd_byte = 8'h72;
      4'd2:    cmd_byte = 8'h15;
      4'd3:    cmd_byte = 8'h00;
      4'd4:    cmd_byte = 8'h5F;
      4'd5:    cmd_byte = 8'h75;
      4'd6:    cmd_byte = 8'h00;
      4'd7:    cmd_byte = 8'h3F;
      default: cmd_byte = 8'hAF;
    endcase
  end

  assign cmd_shifting = (state == ST_CMD) && (cnt < CNT_W'(16));
  assign pix_shifting = (state == ST_STREAM) && primed;

  // NOTE: idle values are assigned first so no path through this block can infer a latch.
  always_comb begin
    sclk = 1'b1;
    sdin = 1'b0;
    if (cmd_shifting) begin
      sclk = cnt[0];
      sdin = cmd_byte[3'd7 - cnt[3:1]];
    end else if (pix_shifting) begin
      sclk = cnt[0];
      sdin = word[4'd15 - cnt[4:1]];
    end
  end

  assign cs_n           = !(cmd_shifting || state == ST_STREAM);
  assign d_cn           = (state == ST_STREAM);
  assign res_n          = (state != ST_RST_LO);
  assign vccen          = (state == ST_PWR_WAIT) || (state == ST_STREAM);
  assign sending_pixels = (state == ST_STREAM);
  assign frame_begin    = pix_shifting && (slot == 5'd0) && (pixel_index == 13'd0);

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Directed bench for oled_frame_streamer: decodes the SPI stream at sclk rises and
// compares bytes, words and event timing against hand-derived values.
module tb_oled_frame_streamer;

  localparam int NPIX    = 128;
  localparam int RST_C   = 20;
  localparam int START_C = 100;
  localparam int FRAME   = 32 * NPIX;

  logic        clk = 1'b0;
  logic        notReset = 1'b0;
  logic [15:0] oled_data = 16'h0000;
  logic [12:0] pixel_index;
  logic        frame_begin, sending_pixels, cs_n, sclk, sdin, d_cn, res_n, vccen, pmoden;

  oled_frame_streamer #(
    .RESET_CYCLES  (RST_C),
    .STARTUP_CYCLES(START_C),
    .NUM_PIXELS    (NPIX)
  ) dut (
    .clk           (clk),
    .notReset      (notReset),
    .oled_data     (oled_data),
    .pixel_index   (pixel_index),
    .frame_begin   (frame_begin),
    .sending_pixels(sending_pixels),
    .cs_n          (cs_n),
    .sclk          (sclk),
    .sdin          (sdin),
    .d_cn          (d_cn),
    .res_n         (res_n),
    .vccen         (vccen),
    .pmoden        (pmoden)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   c;
    logic b;
    logic dc;
  } bit_t;

  bit_t bq[$];
  int   fbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   cs_glitch = 0;
  int   stream_e = 0;
  bit   e_valid = 1'b0;
  bit   aborted = 1'b0;
  int   mode = 0;
  logic prev_sclk = 1'b1;
  logic [12:0] pix_d = '0;
  logic [7:0] cmd_rom [9] = '{8'hA0, 8'h72, 8'h15, 8'h00, 8'h5F, 8'h75, 8'h00, 8'h3F, 8'hAF};

  always @(posedge clk) cyc <= cyc + 1;

  // SPI receiver, event recorder and pattern generator all act on the falling edge.
  always @(negedge clk) begin
    if (!cs_n && sclk && !prev_sclk) bq.push_back('{cyc, sdin, d_cn});
    if (frame_begin) fbq.push_back(cyc);
    if (sending_pixels && cs_n) cs_glitch <= cs_glitch + 1;
    prev_sclk <= sclk;
    pix_d     <= pixel_index;
    case (mode)
      0: oled_data <= {3'b0, pix_d};
      1: oled_data <= 16'hF800;
      default: begin
        if (e_valid && ((cyc - stream_e) % 32 == 31)) oled_data <= 16'h0C00 | {3'b0, pixel_index};
        else oled_data <= cyc[0] ? 16'hFFFF : 16'h0000;
      end
    endcase
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic get_bit(output logic b, output logic dc, output int c);
    bit_t e;
    int   w = 0;
    while (bq.size() == 0 && w < 3000 && !aborted) begin
      @(negedge clk);
      w++;
    end
    if (bq.size() == 0) begin
      if (!aborted) check("bit_timeout", 1, 0);
      aborted = 1'b1;
      b = 1'b0; dc = 1'b0; c = 0;
    end else begin
      e  = bq.pop_front();
      b  = e.b; dc = e.dc; c = e.c;
    end
  endtask

  task automatic get_bits(input int n, output logic [15:0] v, output logic any_dc,
                          output logic all_dc, output int c0, output int clast);
    logic b, dc;
    int   c;
    v = '0; any_dc = 1'b0; all_dc = 1'b1; c0 = 0; clast = 0;
    for (int i = 0; i < n; i++) begin
      get_bit(b, dc, c);
      v = {v[14:0], b};
      any_dc |= dc;
      all_dc &= dc;
      if (i == 0) c0 = c;
      clast = c;
    end
  endtask

  // Release is assumed to have just happened at this falling edge.
  task automatic run_startup(input int rel);
    int n, c0, clast, prev_c0, v_cyc;
    logic [15:0] v;
    logic any_dc, all_dc, cmd_dc;
    n = 0;
    while (res_n === 1'b0 && n < 200) begin n++; @(negedge clk); end
    check("res_lo_len", n, RST_C);
    check("pmoden_on", int'(pmoden), 1);
    n = 0;
    while (cs_n === 1'b1 && n < 200) begin n++; @(negedge clk); end
    check("res_hi_len", n, RST_C);
    check("res_n_high", int'(res_n), 1);
    cmd_dc = 1'b0; prev_c0 = 0; clast = 0;
    for (int b = 0; b < 9; b++) begin
      get_bits(8, v, any_dc, all_dc, c0, clast);
      check($sformatf("cmd_byte%0d", b), int'(v[7:0]), int'(cmd_rom[b]));
      if (b == 0) check("cmd_start", c0, rel + 2 * RST_C + 1);
      else check($sformatf("cmd_gap%0d", b), c0 - prev_c0, 18);
      prev_c0 = c0;
      cmd_dc |= any_dc;
    end
    check("cmd_dcn", int'(cmd_dc), 0);
    n = 0;
    while (vccen !== 1'b1 && n < 200) begin n++; @(negedge clk); end
    v_cyc = cyc;
    check("vccen_rise", v_cyc, clast + 1);
    n = 0;
    while (sending_pixels !== 1'b1 && n < 300) begin n++; @(negedge clk); end
    stream_e = cyc;
    e_valid  = 1'b1;
    check("startup_wait", stream_e - v_cyc, START_C);
    check("entry_pix", int'(pixel_index), 0);
    check("entry_dcn", int'(d_cn), 1);
    check("entry_csn", int'(cs_n), 0);
  endtask

  task automatic reset_and_start();
    @(negedge clk);
    notReset = 1'b0;
    e_valid  = 1'b0;
    repeat (3) @(negedge clk);
    bq.delete();
    fbq.delete();
    notReset = 1'b1;
    run_startup(cyc);
  endtask

  initial begin
    logic [15:0] w;
    logic any_dc, all_dc, dc_ok;
    int c0, clast, n, t_rst, bad, nw;

    // Incrementing pattern, wrap and frame markers.
    mode = 0;
    reset_and_start();
    dc_ok = 1'b1;
    for (int k = 0; k <= NPIX; k++) begin
      get_bits(16, w, any_dc, all_dc, c0, clast);
      dc_ok &= all_dc;
      if (k == 0) check("first_sclk", c0, stream_e + 33);
      if (k < NPIX) check($sformatf("px%0d", k), int'(w), k);
      else check("wrap_word", int'(w), 0);
    end
    check("stream_dcn", int'(dc_ok), 1);
    check("fb_count", fbq.size(), 2);
    check("fb_first", fbq[0], stream_e + 32);
    check("fb_wrap", fbq[1], stream_e + 32 + FRAME);

    // Reset while bit 7 of pixel 100 is on the wire in the second frame.
    t_rst = stream_e + 32 + 32 * (NPIX + 100) + 14;
    n = 0;
    while (cyc < t_rst && n < 20000) begin n++; @(negedge clk); end
    check("pre_rst_cyc", cyc, t_rst);
    check("pre_rst_pix", int'(pixel_index), 101);
    check("pre_rst_sclk", int'(sclk), 0);
    notReset = 1'b0;
    e_valid  = 1'b0;
    #1;
    check("rst_csn", int'(cs_n), 1);
    check("rst_sclk", int'(sclk), 1);
    check("rst_sdin", int'(sdin), 0);
    check("rst_res_n", int'(res_n), 0);
    check("rst_pix", int'(pixel_index), 0);
    check("rst_sending", int'(sending_pixels), 0);
    check("rst_vccen", int'(vccen), 0);
    check("rst_pmoden", int'(pmoden), 0);
    check("rst_dcn", int'(d_cn), 0);

    // Constant red: every word F800, frame_begin every 32*NPIX clk.
    mode = 1;
    reset_and_start();
    for (int k = 0; k < 4; k++) begin
      get_bits(16, w, any_dc, all_dc, c0, clast);
      check($sformatf("red%0d", k), int'(w), 16'hF800);
    end
    n = 0;
    while (fbq.size() < 2 && n < FRAME + 200) begin n++; @(negedge clk); end
    check("red_fb_first", fbq[0], stream_e + 32);
    check("red_fb_period", fbq[1] - fbq[0], FRAME);
    bad = 0; nw = 0;
    while (bq.size() >= 16 && !aborted) begin
      get_bits(16, w, any_dc, all_dc, c0, clast);
      nw++;
      if (w != 16'hF800) bad++;
    end
    check("red_bulk_bad", bad, 0);
    check("red_bulk_seen", int'(nw > NPIX / 2), 1);

    // Data valid only at slot cycle 31; garbage toggles everywhere else.
    mode = 2;
    reset_and_start();
    for (int k = 0; k < 10; k++) begin
      get_bits(16, w, any_dc, all_dc, c0, clast);
      check($sformatf("toggle%0d", k), int'(w), int'(16'h0C00) + k);
    end
    check("cs_held_low", cs_glitch, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
